fp16_sort_sequencer: RTL and testbench

Batch sorter for IEEE-754 half-precision words. It accepts DEPTH fp16 values over a valid/ready stream and sorts them in place in a register array. Sorting is an odd-even transposition sort that drives one shared magnitude comparator, one compare-and-swap per cycle. The sorted batch is then streamed out in ascending order. The block sits between an fp16 producer and a consumer that needs ordered data, such as median or top-k selection.

---
 rtl/fp16_sort_sequencer.sv | 162 ++++++++++++++++
 tb/tb_fp16_sort_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fp16_sort_sequencer.sv
// Batch sorter for fp16 words: load DEPTH words, odd-even transposition
// sort with one shared comparator, then stream out in ascending order.
module fp16_sort_sequencer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        unordered
);

  localparam int IW   = $clog2(DEPTH);
  localparam int PW   = IW - 1;
  localparam int HALF = DEPTH / 2;
  localparam logic [IW-1:0] LAST_IDX   = IW'(DEPTH - 1);
  localparam logic [PW-1:0] LAST_EVEN  = PW'(HALF - 1);
  localparam logic [PW-1:0] LAST_ODD   = PW'(HALF - 2);

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] wr_cnt_q, wr_cnt_d;
  logic [IW-1:0] rd_ptr_q, rd_ptr_d;
  logic [IW-1:0] pass_q, pass_d;
  logic [PW-1:0] pair_q, pair_d;
  logic          unord_q, unord_d;
  logic [15:0]   arr_q [DEPTH];
  logic [15:0]   arr_d [DEPTH];

  logic [IW-1:0] lo_idx;
  logic [IW-1:0] hi_idx;
  logic [15:0]   a_w;
  logic [15:0]   b_w;
  logic          pair_unord;
  logic          a_gt;
  logic          last_pair;

  // Pair selection and the shared magnitude comparator
  always_comb begin
    lo_idx     = {pair_q, pass_q[0]};
    hi_idx     = lo_idx + IW'(1);
    a_w        = arr_q[lo_idx];
    b_w        = arr_q[hi_idx];
    pair_unord = (a_w[14:10] == 5'd0) || (a_w[14:10] == 5'd31) ||
                 (b_w[14:10] == 5'd0) || (b_w[14:10] == 5'd31);
    if (a_w[15] != b_w[15]) begin
      a_gt = !a_w[15];
    end else if (!a_w[15]) begin
      a_gt = a_w[14:0] > b_w[14:0];
    end else begin
      a_gt = a_w[14:0] < b_w[14:0];
    end
    last_pair = pass_q[0] ? (pair_q == LAST_ODD)
                          : (pair_q == LAST_EVEN);
  end

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_ptr_d  = rd_ptr_q;
    pass_d    = pass_q;
    pair_d    = pair_q;
    unord_d   = unord_q;
    arr_d     = arr_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 16'h0000;
    out_last  = 1'b0;
    unique case (state_q)
      LOAD: begin
        in_ready = !rst;
        if (in_valid && in_ready) begin
          arr_d[wr_cnt_q] = in_data;
          if (wr_cnt_q == '0) begin
            unord_d = 1'b0;
          end
          if (wr_cnt_q == LAST_IDX) begin
            wr_cnt_d = '0;
            pass_d   = '0;
            pair_d   = '0;
            state_d  = SORT;
          end else begin
            wr_cnt_d = wr_cnt_q + IW'(1);
          end
        end
      end
      SORT: begin
        if (pair_unord) begin
          unord_d = 1'b1;
        end else if (a_gt) begin
          arr_d[lo_idx] = b_w;
          arr_d[hi_idx] = a_w;
        end
        if (last_pair) begin
          pair_d = '0;
          if (pass_q == LAST_IDX) begin
            rd_ptr_d = '0;
            state_d  = DRAIN;
          end else begin
            pass_d = pass_q + IW'(1);
          end
        end else begin
          pair_d = pair_q + PW'(1);
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = arr_q[rd_ptr_q];
        out_last  = rd_ptr_q == LAST_IDX;
        if (out_ready) begin
          if (out_last) begin
            rd_ptr_d = '0;
            state_d  = LOAD;
          end else begin
            rd_ptr_d = rd_ptr_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  assign busy      = (state_q != LOAD) || (wr_cnt_q != '0);
  assign unordered = unord_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD;
      wr_cnt_q <= '0;
      rd_ptr_q <= '0;
      pass_q   <= '0;
      pair_q   <= '0;
      unord_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      pass_q   <= pass_d;
      pair_q   <= pair_d;
      unord_q  <= unord_d;
    end
  end

  // Payload storage needs no reset; a discarded batch is simply overwritten
  always_ff @(posedge clk) begin
    arr_q <= arr_d;
  end

endmodule

// File: tb/tb_fp16_sort_sequencer.sv
// Directed bench for fp16_sort_sequencer: ordering, latency,
// unordered flag, backpressure, mid-batch reset and sparse input.
module tb_fp16_sort_sequencer;

  typedef logic [15:0] vec_t [8];

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        unordered;

  int checks;
  int errors;

  vec_t v_mix  = '{16'h4400, 16'h3C00, 16'hC000, 16'h4200,
                   16'h3800, 16'hBC00, 16'h4000, 16'h3E00};
  vec_t v_srt  = '{16'hC000, 16'hBC00, 16'h3800, 16'h3C00,
                   16'h3E00, 16'h4000, 16'h4200, 16'h4400};
  vec_t v_dup  = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00,
                   16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
  vec_t v_inf  = '{16'h0000, 16'h4400, 16'hC000, 16'h4200,
                   16'h3800, 16'hBC00, 16'h4000, 16'h7C00};
  vec_t e_inf  = '{16'h0000, 16'hC000, 16'hBC00, 16'h3800,
                   16'h4000, 16'h4200, 16'h4400, 16'h7C00};

  fp16_sort_sequencer #(.DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .unordered (unordered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] d);
    int g;
    g = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) chk("push_timeout", 16'(in_ready), 16'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < 8; i++) push(v[i]);
  endtask

  task automatic wait_out();
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 200);
    chk("latency", 16'(cyc), 16'd29);
  endtask

  task automatic drain(input vec_t e, input int stall_at,
                       input logic e_unord);
    int g;
    logic [15:0] hd;
    logic hl;
    for (int i = 0; i < 8; i++) begin
      g = 0;
      @(negedge clk);
      while (!out_valid && g < 100) begin
        @(negedge clk);
        g++;
      end
      chk($sformatf("data%0d", i), out_data, e[i]);
      chk($sformatf("last%0d", i), 16'(out_last), 16'(i == 7));
      chk($sformatf("unord%0d", i), 16'(unordered), 16'(e_unord));
      chk($sformatf("inrdy%0d", i), 16'(in_ready), 16'd0);
      if (i == stall_at) begin
        hd = out_data;
        hl = out_last;
        repeat (5) begin
          @(negedge clk);
          chk("stall_data", out_data, hd);
          chk("stall_last", 16'(out_last), 16'(hl));
          chk("stall_inrdy", 16'(in_ready), 16'd0);
        end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
    @(negedge clk);
    chk("post_inrdy", 16'(in_ready), 16'd1);
    chk("post_oval", 16'(out_valid), 16'd0);
    chk("post_busy", 16'(busy), 16'd0);
    chk("post_unord", 16'(unordered), 16'(e_unord));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_inrdy", 16'(in_ready), 16'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_inrdy1", 16'(in_ready), 16'd1);
    chk("rst_oval", 16'(out_valid), 16'd0);
    chk("rst_odata", out_data, 16'h0000);
    chk("rst_olast", 16'(out_last), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_unord", 16'(unordered), 16'd0);
  endtask

  initial begin
    int idx;
    int k;
    logic hs;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    load(v_mix);
    wait_out();
    drain(v_srt, -1, 1'b0);

    load(v_srt);
    wait_out();
    drain(v_srt, -1, 1'b0);

    load(v_dup);
    wait_out();
    drain(v_dup, -1, 1'b0);

    load(v_inf);
    wait_out();
    drain(e_inf, -1, 1'b1);

    push(v_mix[0]);
    @(negedge clk);
    chk("unord_clr", 16'(unordered), 16'd0);
    chk("busy_part", 16'(busy), 16'd1);
    for (int i = 1; i < 8; i++) push(v_mix[i]);
    wait_out();
    drain(v_srt, 3, 1'b0);

    for (int i = 0; i < 3; i++) push(v_mix[i]);
    @(negedge clk);
    chk("busy3", 16'(busy), 16'd1);
    do_reset();

    load(v_inf);
    repeat (10) @(negedge clk);
    chk("sort_busy", 16'(busy), 16'd1);
    chk("sort_unord", 16'(unordered), 16'd1);
    do_reset();

    load(v_mix);
    wait_out();
    drain(v_srt, -1, 1'b0);

    idx = 0;
    k   = 0;
    out_ready = 1'b1;
    while (idx < 8 && k < 200) begin
      @(negedge clk);
      in_valid = (k % 2) == 0;
      in_data  = in_valid ? v_mix[idx] : 16'hFFFF;
      hs = in_valid && in_ready;
      @(posedge clk);
      if (hs) idx++;
      k++;
    end
    #1 in_valid = 1'b0;
    out_ready = 1'b0;
    chk("toggle_cnt", 16'(idx), 16'd8);
    wait_out();
    drain(v_srt, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
